// File: rtl/mvm_job_sequencer.sv
// Sequences one complete matrix-vector job on the 8x8 MAC array: clear, fetch B and eight
// A columns from word memory, fill the array FIFOs, wait for done, then stream the results.
module mvm_job_sequencer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                base_addr,
    output logic                             busy,
    output logic                             job_done,
    output logic                             err,
    output logic                             mem_req,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic                             mem_gnt,
    input  logic                             mem_rvalid,
    input  logic [8*DATA_WIDTH-1:0]          mem_rdata,
    output logic                             mvm_Clr,
    output logic                             mvm_a_wren,
    output logic                             mvm_b_wren,
    output logic [7:0][DATA_WIDTH-1:0]       mvm_a_fifo_in,
    output logic [DATA_WIDTH-1:0]            mvm_b_fifo_in,
    input  logic                             mvm_done,
    input  logic [7:0][3*DATA_WIDTH-1:0]     mvm_out,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [3*DATA_WIDTH-1:0]          res_data,
    output logic [2:0]                       res_idx,
    output logic                             res_last
);

    localparam int unsigned ResW = 3 * DATA_WIDTH;
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFetchB,
        StFetchA,
        StWaitDone,
        StCapture,
        StDrain
    } state_e;

    state_e                       state_q, state_d;
    logic [ADDR_W-1:0]            base_q, base_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic                         req_q, req_d;
    logic                         pend_q, pend_d;
    logic                         err_q, err_d;
    logic [2:0]                   k_q, k_d;
    logic                         last_wr_q, last_wr_d;
    logic [7:0][DATA_WIDTH-1:0]   b_q, b_d;
    logic [7:0][DATA_WIDTH-1:0]   a_data_q, a_data_d;
    logic [DATA_WIDTH-1:0]        b_data_q, b_data_d;
    logic                         wren_q, wren_d;
    logic                         done_dly_q;
    logic [CntW-1:0]              wait_q, wait_d;
    logic [7:0][ResW-1:0]         res_q, res_d;
    logic [2:0]                   idx_q, idx_d;
    logic                         job_done_q, job_done_d;
    logic [7:0][DATA_WIDTH-1:0]   rword;
    logic                         done_rise;

    assign rword     = mem_rdata;
    // A done level carried over from the previous job never looks like a rise.
    assign done_rise = mvm_done & ~done_dly_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        addr_d     = addr_q;
        req_d      = req_q;
        pend_d     = pend_q;
        err_d      = err_q;
        k_d        = k_q;
        last_wr_d  = last_wr_q;
        b_d        = b_q;
        a_data_d   = a_data_q;
        b_data_d   = b_data_q;
        wren_d     = 1'b0;
        wait_d     = wait_q;
        res_d      = res_q;
        idx_d      = idx_q;
        job_done_d = 1'b0;

        if (req_q && mem_gnt) begin
            req_d  = 1'b0;
            pend_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base_addr;
                    err_d   = 1'b0;
                    state_d = StClear;
                end
            end
            StClear: begin
                req_d   = 1'b1;
                addr_d  = base_q;
                state_d = StFetchB;
            end
            StFetchB: begin
                if (pend_q && mem_rvalid) begin
                    b_d     = rword;
                    pend_d  = 1'b0;
                    k_d     = 3'd0;
                    req_d   = 1'b1;
                    addr_d  = base_q + ADDR_W'(1);
                    state_d = StFetchA;
                end
            end
            StFetchA: begin
                if (pend_q && mem_rvalid) begin
                    pend_d   = 1'b0;
                    wren_d   = 1'b1;
                    a_data_d = rword;
                    b_data_d = b_q[k_q];
                    if (k_q == 3'd7) begin
                        last_wr_d = 1'b1;
                    end else begin
                        // Next column request overlaps the FIFO write of this one.
                        k_d    = k_q + 3'd1;
                        req_d  = 1'b1;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                if (last_wr_q) begin
                    last_wr_d = 1'b0;
                    wait_d    = '0;
                    state_d   = StWaitDone;
                end
            end
            StWaitDone: begin
                if (done_rise) begin
                    state_d = StCapture;
                end else if (wait_q == CntW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + CntW'(1);
                end
            end
            StCapture: begin
                res_d   = mvm_out;
                idx_d   = 3'd0;
                state_d = StDrain;
            end
            StDrain: begin
                if (res_ready) begin
                    if (idx_q == 3'd7) begin
                        job_done_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            base_q     <= '0;
            addr_q     <= '0;
            req_q      <= 1'b0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            k_q        <= '0;
            last_wr_q  <= 1'b0;
            b_q        <= '0;
            a_data_q   <= '0;
            b_data_q   <= '0;
            wren_q     <= 1'b0;
            done_dly_q <= 1'b0;
            wait_q     <= '0;
            res_q      <= '0;
            idx_q      <= '0;
            job_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            k_q        <= k_d;
            last_wr_q  <= last_wr_d;
            b_q        <= b_d;
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
            wren_q     <= wren_d;
            done_dly_q <= mvm_done;
            wait_q     <= wait_d;
            res_q      <= res_d;
            idx_q      <= idx_d;
            job_done_q <= job_done_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign job_done      = job_done_q;
    assign err           = err_q;
    assign mem_req       = req_q;
    assign mem_addr      = addr_q;
    assign mvm_Clr       = (state_q == StClear);
    assign mvm_a_wren    = wren_q;
    assign mvm_b_wren    = wren_q;
    assign mvm_a_fifo_in = a_data_q;
    assign mvm_b_fifo_in = b_data_q;
    assign res_valid     = (state_q == StDrain);
    assign res_data      = res_q[idx_q];
    assign res_idx       = idx_q;
    assign res_last      = res_valid && (idx_q == 3'd7);

endmodule
